adc_sdo_emulator: RTL

Synthesizable model of the LTC2325-16 serial output side: the responder that accepts CNV_N and the forwarded ADC clock and serializes 16-bit words, MSB first, onto NCH SDO lines plus an echoed CLKOUT. It is used for FPGA-internal loopback and bench checks of the ADC capture path without a physical ADC. Data source is either an externally supplied parallel word set or an internal per-channel ramp.

---
 rtl/adc_sdo_emulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/adc_sdo_emulator.sv
// rtl/adc_sdo_emulator.sv - LTC2325-16 style serial output emulator
// Snapshots DIN or a per-channel ramp on CNV_N rise, then shifts MSB first on SCK falls.
module adc_sdo_emulator #(
  parameter int NCH         = 20,
  parameter int CONV_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              PATTERN,
  input  logic [NCH*16-1:0] DIN,
  input  logic              CNV_N,
  input  logic              SCK,
  output logic [NCH-1:0]    SDO,
  output logic              CLKOUT,
  output logic              BUSY,
  output logic              TIMING_ERR,
  output logic [31:0]       CONV_CNT
);

  localparam int CW = $clog2(CONV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t          state, state_n;
  logic            cnv_q, sck_q;
  logic            cnv_rise, cnv_fall, sck_fall;
  logic [15:0]     shreg [NCH];
  logic [15:0]     ramp;
  logic [CW-1:0]   conv_cnt;
  logic [4:0]      bit_cnt;

  logic            do_snap, do_load, do_shift, do_last, busy_clr, err;

  assign cnv_rise = !cnv_q && CNV_N;
  assign cnv_fall = cnv_q && !CNV_N;
  assign sck_fall = sck_q && !SCK;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // A CNV_N rise always wins; it restarts conversion from any state.
  always_comb begin
    state_n  = state;
    do_snap  = 1'b0;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_last  = 1'b0;
    busy_clr = 1'b0;
    err      = 1'b0;
    if (cnv_rise) begin
      do_snap = 1'b1;
      err     = (state == CONV) || (state == SHIFT);
      state_n = CONV;
    end else begin
      case (state)
        CONV: begin
          if (cnv_fall) begin
            err      = BUSY;
            busy_clr = BUSY;
            do_load  = 1'b1;
            state_n  = SHIFT;
          end else if (BUSY && conv_cnt == CW'(1)) begin
            busy_clr = 1'b1;
          end
        end
        SHIFT: begin
          if (sck_fall) begin
            do_shift = 1'b1;
            if (bit_cnt == 5'd15) begin
              do_last = 1'b1;
              state_n = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnv_q      <= 1'b1;
      sck_q      <= 1'b0;
      CLKOUT     <= 1'b0;
      SDO        <= '0;
      BUSY       <= 1'b0;
      TIMING_ERR <= 1'b0;
      CONV_CNT   <= '0;
      ramp       <= '0;
      conv_cnt   <= '0;
      bit_cnt    <= '0;
      for (int i = 0; i < NCH; i++) shreg[i] <= '0;
    end else begin
      cnv_q      <= CNV_N;
      sck_q      <= SCK;
      CLKOUT     <= SCK;
      TIMING_ERR <= err;
      if (do_snap) begin
        for (int i = 0; i < NCH; i++)
          shreg[i] <= PATTERN ? (ramp + 16'(i)) : DIN[16*i +: 16];
        if (PATTERN) ramp <= ramp + 16'd1;
        CONV_CNT <= CONV_CNT + 32'd1;
        conv_cnt <= CW'(CONV_CYCLES);
        BUSY     <= 1'b1;
        SDO      <= '0;
      end else begin
        if (state == CONV && conv_cnt != '0) conv_cnt <= conv_cnt - CW'(1);
        if (busy_clr) BUSY <= 1'b0;
        if (do_load) begin
          conv_cnt <= '0;
          bit_cnt  <= '0;
          for (int i = 0; i < NCH; i++) SDO[i] <= shreg[i][15];
        end
        // SDO presents the next MSB so it is stable at the following CLKOUT rise.
        if (do_shift) begin
          bit_cnt <= bit_cnt + 5'd1;
          for (int i = 0; i < NCH; i++) begin
            shreg[i] <= shreg[i] << 1;
            SDO[i]   <= do_last ? 1'b0 : shreg[i][14];
          end
        end
      end
    end
  end

endmodule
